io_uart_responder: RTL and testbench

Memory-mapped IO responder on the core's IO port. It decodes IO-space loads and stores, holds the LED register, and serialises bytes to a UART transmit line through a small TX FIFO. It sits in the SoC between the core's `IO_mem_*` signals and the board pins (`LEDS`, `UART_TX`).

---
 rtl/io_map_pkg.sv | 10 +
 rtl/tx_fifo.sv | 43 ++++
 rtl/io_uart_responder.sv | 131 +++++++++++++
 tb/tb_io_uart_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// io_map_pkg: IO-space word-address select bits, status bit positions and TX state encoding.
package io_map_pkg;
    localparam int IO_LED_BIT       = 0;
    localparam int IO_UART_DATA_BIT = 1;
    localparam int IO_UART_STAT_BIT = 2;
    localparam int ST_OVF  = 10;
    localparam int ST_FULL = 9;
    localparam int ST_BUSY = 8;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CNTW = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full    = count == CNTW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNTW'(do_push) - CNTW'(do_pop);
        end
    end
endmodule

// File: rtl/io_uart_responder.sv
// io_uart_responder: IO-space decode, LED register and FIFO-buffered 8N1 UART transmitter.
module io_uart_responder #(
    parameter int CLK_FREQ_HZ = 10000000,
    parameter int BAUD_RATE   = 1000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] IO_mem_addr,
    input  logic [31:0] IO_mem_wdata,
    input  logic        IO_mem_wr,
    output logic [31:0] IO_mem_rdata,
    output logic [5:0]  LEDS,
    output logic        UART_TX
);
    import io_map_pkg::*;

    localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

    logic sel_led, sel_data, sel_stat, wr_data, busy, ovf, last;
    logic fifo_pop, fifo_full, fifo_empty, tx_n;
    logic [7:0] fifo_dout, shreg, shreg_n;
    logic [AW:0] fifo_count;
    logic [CW-1:0] baud, baud_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [31:0] status;
    tx_state_t state, state_n;
    logic unused_bits;

    assign unused_bits = ^{IO_mem_addr[31:5], IO_mem_addr[1:0], IO_mem_wdata[31:11], IO_mem_wdata[9:8]};
    assign sel_led  = IO_mem_addr[2 + IO_LED_BIT];
    assign sel_data = IO_mem_addr[2 + IO_UART_DATA_BIT];
    assign sel_stat = IO_mem_addr[2 + IO_UART_STAT_BIT];
    assign wr_data  = IO_mem_wr && sel_data;
    assign busy     = (state != TX_IDLE) || !fifo_empty;
    assign last     = baud == '0;

    always_comb begin
        status          = '0;
        status[ST_OVF]  = ovf;
        status[ST_FULL] = fifo_full;
        status[ST_BUSY] = busy;
        status[4:0]     = 5'(fifo_count);
    end

    // Reads are pure decode: the core drives addresses for non-load instructions too.
    assign IO_mem_rdata = (sel_led ? {26'b0, LEDS} : 32'b0) | (sel_stat ? status : 32'b0);

    tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (wr_data),
        .din    (IO_mem_wdata[7:0]),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        state_n   = state;
        baud_n    = last ? BIT_LAST : baud - CW'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        tx_n      = UART_TX;
        fifo_pop  = 1'b0;
        case (state)
            TX_IDLE: begin
                baud_n = BIT_LAST;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_n  = fifo_dout;
                    state_n  = TX_START;
                    tx_n     = 1'b0;
                end
            end
            TX_START: if (last) begin
                state_n   = TX_DATA;
                bit_idx_n = 3'd0;
                tx_n      = shreg[0];
            end
            TX_DATA: if (last) begin
                if (bit_idx == 3'd7) begin
                    state_n = TX_STOP;
                    tx_n    = 1'b1;
                end else begin
                    bit_idx_n = bit_idx + 3'd1;
                    shreg_n   = shreg >> 1;
                    tx_n      = shreg[1];
                end
            end
            TX_STOP: if (last) begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_n  = fifo_dout;
                    state_n  = TX_START;
                    tx_n     = 1'b0;
                end else begin
                    state_n = TX_IDLE;
                end
            end
            default: state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= TX_IDLE;
            baud    <= BIT_LAST;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            UART_TX <= 1'b1;
            LEDS    <= 6'd0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            UART_TX <= tx_n;
            if (IO_mem_wr && sel_led) LEDS <= IO_mem_wdata[5:0];
            // A dropped byte outranks a simultaneous clear.
            if (wr_data && fifo_full && !fifo_pop) ovf <= 1'b1;
            else if (IO_mem_wr && sel_stat && IO_mem_wdata[ST_OVF]) ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_io_uart_responder.sv
// tb_io_uart_responder: scoreboard bench; a line receiver pops expected bytes as frames arrive.
module tb_io_uart_responder;
    localparam int DIV = 10;
    localparam logic [31:0] A_LED  = 32'h0040_0004;
    localparam logic [31:0] A_DATA = 32'h0040_0008;
    localparam logic [31:0] A_STAT = 32'h0040_0010;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic IO_mem_wr = 1'b0;
    logic [31:0] IO_mem_addr = 32'd0;
    logic [31:0] IO_mem_wdata = 32'd0;
    logic [31:0] IO_mem_rdata;
    logic [5:0] LEDS;
    logic UART_TX;

    int n_chk = 0, n_pass = 0, cyc = 0, rst_events = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    io_uart_responder #(.CLK_FREQ_HZ(10000000), .BAUD_RATE(1000000), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .IO_mem_addr  (IO_mem_addr),
        .IO_mem_wdata (IO_mem_wdata),
        .IO_mem_wr    (IO_mem_wr),
        .IO_mem_rdata (IO_mem_rdata),
        .LEDS         (LEDS),
        .UART_TX      (UART_TX)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge resetn) rst_events <= rst_events + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        IO_mem_addr = a;
        IO_mem_wdata = v;
        IO_mem_wr = 1'b1;
        @(negedge clk);
        IO_mem_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        IO_mem_addr = a;
        #1;
        v = IO_mem_rdata;
    endtask

    function automatic logic line_bit(input logic [7:0] b, input int k);
        return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
    endfunction

    initial begin : rx
        logic [7:0] b;
        logic st, sp;
        int ev;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && UART_TX === 1'b0) begin
                ev = rst_events;
                starts.push_back(cyc);
                repeat (DIV/2) @(negedge clk);
                st = UART_TX;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = UART_TX;
                end
                repeat (DIV) @(negedge clk);
                sp = UART_TX;
                if (ev == rst_events) begin
                    check("rx_start", st, 0);
                    check("rx_stop", sp, 1);
                    if (exp_q.size() == 0) check("rx_spurious", b, 32'h100);
                    else check("rx_byte", b, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int s0, bad;
        repeat (3) @(negedge clk);
        check("rst_leds", LEDS, 0);
        check("rst_tx", UART_TX, 1);
        rd(A_STAT, d);
        check("rst_stat", d, 0);
        resetn = 1'b1;
        @(negedge clk);
        rd(A_STAT, d);
        check("post_rst_stat", d, 0);

        exp_q.push_back(8'h55);
        store(A_DATA, 32'h55);
        rd(A_STAT, d);
        check("stat_queued", d, 32'h101);
        for (int i = 0; i < 10*DIV; i++) begin
            @(negedge clk);
            check($sformatf("line%0d", i), UART_TX, line_bit(8'h55, i / DIV));
            if (i == 50) begin
                rd(A_STAT, d);
                check("stat_busy", d, 32'h100);
            end
        end
        repeat (2) @(negedge clk);
        rd(A_STAT, d);
        check("stat_idle", d, 0);

        s0 = starts.size();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h41 + i));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            IO_mem_addr = A_DATA;
            IO_mem_wdata = 32'h41 + i;
            IO_mem_wr = 1'b1;
        end
        @(negedge clk);
        IO_mem_wr = 1'b0;
        rd(A_STAT, d);
        check("stat_ovf", d, 32'h704);
        store(32'h0040_0018, 32'h400);
        rd(A_STAT, d);
        check("ovf_set_wins", d, 32'h704);
        store(A_STAT, 32'h400);
        rd(A_STAT, d);
        check("ovf_clear", d, 32'h304);
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        check("frames", starts.size() - s0, 5);
        for (int i = 1; i < 5 && s0 + i < starts.size(); i++)
            check("frame_gap", starts[s0+i] - starts[s0+i-1], 10*DIV);
        repeat (DIV + 2) @(negedge clk);
        rd(A_STAT, d);
        check("stat_after_ovf", d, 0);

        store(A_LED, 32'hFFFF_FFEA);
        check("leds", LEDS, 6'h2A);
        rd(A_LED, d);
        check("led_rd", d, 32'h2A);
        rd(A_DATA, d);
        check("data_rd", d, 0);
        rd(32'h0040_0014, d);
        check("multi_rd", d, 32'h2A);

        store(32'h0040_0000, 32'h33);
        check("dec_leds", LEDS, 6'h2A);
        rd(A_STAT, d);
        check("dec_stat", d, 0);
        rd(32'h0040_0000, d);
        check("dec_rd", d, 0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (UART_TX !== 1'b1) bad++;
        end
        check("dec_quiet", bad, 0);

        exp_q.push_back(8'hA5);
        store(A_DATA, 32'hA5);
        repeat (45) @(negedge clk);
        check("pre_rst_line", UART_TX, 0);
        #2 resetn = 1'b0;
        #1 check("rst_async_tx", UART_TX, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        rd(A_STAT, d);
        check("rst_mid_stat", d, 0);
        check("rst_mid_leds", LEDS, 0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (UART_TX !== 1'b1) bad++;
        end
        check("rst_quiet", bad, 0);
        check("rx_left", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
